// File: rtl/bit_split_ctrl.sv
// rtl/bit_split_ctrl.sv - serial bit front end: even/odd split, toggle select, framing (optional parity: BIT_SPLIT_PARITY_EN)
module bit_split_ctrl #(
    parameter int FRAME_BITS = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             even,
    output logic             odd,
    output logic             tffout,
    output logic             bit_strobe,
    output logic [CNT_W-1:0] bit_count,
    output logic             busy,
    output logic             frame_done,
    input  logic             frame_ack,
    output logic             parity_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

    state_t state, state_nxt;
    logic   accept;
    logic   last_bit;
    logic   frame_start;

    assign accept      = (state == RUN) && din_valid;
    assign last_bit    = (bit_count == LAST_IDX);
    assign frame_start = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake and status flags are decoded from state alone.
    always_comb begin
        state_nxt  = state;
        din_ready  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (din_valid && last_bit) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                if (frame_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // bit_count[0] is the index parity of the bit being accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            even       <= 1'b0;
            odd        <= 1'b0;
            tffout     <= 1'b0;
            bit_strobe <= 1'b0;
            bit_count  <= '0;
        end else begin
            bit_strobe <= accept;
            if (frame_start) begin
                bit_count <= '0;
            end else if (accept) begin
                bit_count <= bit_count + CNT_W'(1);
                if (!bit_count[0]) begin
                    even   <= din;
                    tffout <= 1'b0;
                end else begin
                    odd    <= din;
                    tffout <= 1'b1;
                end
            end
        end
    end

`ifdef BIT_SPLIT_PARITY_EN
    logic par_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_acc    <= 1'b0;
            parity_out <= 1'b0;
        end else if (frame_start) begin
            par_acc    <= 1'b0;
            parity_out <= 1'b0;
        end else if (accept) begin
            par_acc <= par_acc ^ din;
            if (last_bit) parity_out <= par_acc ^ din;
        end
    end
`else
    assign parity_out = 1'b0;
`endif

endmodule

// File: tb/tb_bit_split_ctrl.sv
// tb/tb_bit_split_ctrl.sv - self-checking bench for bit_split_ctrl
module tb_bit_split_ctrl;

    localparam int FRAME_BITS = 8;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             reset, start, din, din_valid, frame_ack;
    logic             din_ready, even, odd, tffout, bit_strobe, busy, frame_done, parity_out;
    logic [CNT_W-1:0] bit_count;

    bit_split_ctrl #(.FRAME_BITS(FRAME_BITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .even(even), .odd(odd), .tffout(tffout),
        .bit_strobe(bit_strobe), .bit_count(bit_count), .busy(busy),
        .frame_done(frame_done), .frame_ack(frame_ack), .parity_out(parity_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: the frame is a list of accepted bits; outputs derive from it.
    int phase = 0;              // 0 waiting for start, 1 collecting, 2 complete
    bit fbits[$];
    bit m_even, m_odd, m_tff, m_strobe, m_par;
    int m_count;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int par;
        m_strobe = 1'b0;
        if (reset) begin
            phase = 0; fbits.delete();
            m_even = 0; m_odd = 0; m_tff = 0; m_count = 0; m_par = 0;
        end else if (phase == 0) begin
            if (start) begin
                phase = 1; fbits.delete(); m_count = 0; m_par = 0;
            end
        end else if (phase == 1) begin
            if (din_valid) begin
                fbits.push_back(din);
                m_strobe = 1'b1;
                m_count  = fbits.size();
                if ((m_count % 2) == 1) begin m_even = din; m_tff = 0; end
                else begin m_odd = din; m_tff = 1; end
                if (m_count == FRAME_BITS) begin
                    phase = 2;
`ifdef BIT_SPLIT_PARITY_EN
                    par = 0;
                    foreach (fbits[i]) par += fbits[i];
                    m_par = par[0];
`endif
                end
            end
        end else begin
            if (frame_ack) phase = 0;
        end
    endtask

    function automatic int dut_vec();
        return {din_ready, even, odd, tffout, bit_strobe, bit_count, busy, frame_done, parity_out};
    endfunction

    function automatic int model_vec();
        bit [CNT_W-1:0] c;
        c = m_count[CNT_W-1:0];
        return {phase == 1, m_even, m_odd, m_tff, m_strobe, c, phase == 1, phase == 2, m_par};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("cycle", dut_vec(), model_vec());
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; din = 0; din_valid = 0; frame_ack = 0;
    endtask

    task automatic send_frame(input bit [7:0] bits, input int gap_after);
        start = 1; tick(); start = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            din = bits[7-i]; din_valid = 1; tick();
            din_valid = 0;
            if (i == gap_after) begin
                repeat (3) tick();
                chk("gap_strobe", bit_strobe, 0);
            end
        end
    endtask

    typedef struct {
        bit start, din, valid, ack;
        bit [3:0] count;
        bit e, o, t, s, d;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1,0,0,0, 0, 0,0,0,0,0};
        tbl[1] = '{0,1,1,0, 1, 1,0,0,1,0};
        tbl[2] = '{0,0,1,0, 2, 1,0,1,1,0};
        tbl[3] = '{0,1,1,0, 3, 1,0,0,1,0};
        tbl[4] = '{0,1,1,0, 4, 1,1,1,1,0};
        tbl[5] = '{0,0,1,0, 5, 0,1,0,1,0};
        tbl[6] = '{0,0,1,0, 6, 0,0,1,1,0};
        tbl[7] = '{0,1,1,0, 7, 1,0,0,1,0};
        tbl[8] = '{0,0,1,0, 8, 1,0,1,1,1};
        tbl[9] = '{0,0,0,1, 8, 1,0,1,0,0};

        idle_inputs();
        reset = 1; tick(); tick();
        chk("reset_ready", din_ready, 0);
        chk("reset_count", bit_count, 0);
        reset = 0;

        // Directed frame 1,0,1,1,0,0,1,0 from the table.
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start; din = tbl[i].din;
            din_valid = tbl[i].valid; frame_ack = tbl[i].ack;
            tick();
            chk($sformatf("tbl%0d", i),
                {bit_count, even, odd, tffout, bit_strobe, frame_done},
                {tbl[i].count, tbl[i].e, tbl[i].o, tbl[i].t, tbl[i].s, tbl[i].d});
        end
        idle_inputs();
        chk("after_ack_ready", din_ready, 0);

        // Same frame with a 3-cycle gap after bit 3; DONE ignores din_valid.
        send_frame(8'b1011_0010, 2);
        chk("gap_final", {even, odd, tffout, bit_count, frame_done}, {1'b1, 1'b0, 1'b1, 4'd8, 1'b1});
        din_valid = 1; din = 1;
        repeat (5) tick();
        din_valid = 0; frame_ack = 1; tick(); frame_ack = 0;
        chk("ack_idle", {frame_done, din_ready, busy}, 0);

        // Reset after the 5th bit, then a full frame.
        start = 1; tick(); start = 0;
        for (int i = 0; i < 5; i++) begin din = 1; din_valid = 1; tick(); end
        din_valid = 0; reset = 1; tick(); reset = 0;
        chk("midreset", dut_vec(), 0);
        send_frame(8'b1011_0011, -1);
        chk("frame2_done", {frame_done, bit_count}, {1'b1, 4'd8});
`ifdef BIT_SPLIT_PARITY_EN
        chk("parity_odd", parity_out, 1);
`endif

        // start with ack in DONE: ack wins, new start required.
        start = 1; frame_ack = 1; tick(); start = 0; frame_ack = 0;
        chk("start_ack_busy", busy, 0);
        tick();
        chk("start_ack_ready", din_ready, 0);
        start = 1; tick(); start = 0;
        chk("restart_ready", din_ready, 1);
        chk("restart_parity", parity_out, 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 3) == 0);
            din       = $urandom_range(0, 1);
            din_valid = ($urandom_range(0, 3) != 0);
            frame_ack = ($urandom_range(0, 4) == 0);
            tick();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
